// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: round-robin arbiter that merges completions from NUM_REQ
// execution units onto WB_WIDTH registered ROB writeback ports.
// Grants are combinational; the writeback slots are registered, with one cycle of latency.
module rob_wb_arbiter #(
  parameter int NUM_REQ              = 4,
  parameter int WB_WIDTH             = 2,
  parameter int PHYS_REGS_ADDR_WIDTH = 6,
  parameter int ROB_ADDR_WIDTH       = 3,
  parameter int BANK_ADDR_WIDTH      = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           flush,
  input  logic [NUM_REQ-1:0]                             req_valid,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic [NUM_REQ-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   req_phys_rd,
  input  logic [NUM_REQ-1:0][ROB_ADDR_WIDTH-1:0]         req_rob_addr,
  input  logic [NUM_REQ-1:0][BANK_ADDR_WIDTH-1:0]        req_bank_addr,
  output logic [WB_WIDTH-1:0]                            wb_en,
  output logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  wb_phys_rd,
  output logic [WB_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]        wb_rob_addr,
  output logic [WB_WIDTH-1:0][BANK_ADDR_WIDTH-1:0]       wb_bank_addr
);

  // Pointer width; a single requester still needs a one-bit pointer.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                rr_ptr_reg;
  logic [PTR_W-1:0]                rr_ptr_next;
  logic [NUM_REQ-1:0]              grant;
  logic [WB_WIDTH-1:0]             slot_en_next;
  logic [WB_WIDTH-1:0][PTR_W-1:0]  slot_sel;

  // Scan from rr_ptr with wrap-around, handing the first WB_WIDTH valid
  // requesters to slots in scan order; flush blocks every grant.
  always_comb begin
    int              cnt;
    int              idx;
    logic [PTR_W-1:0] idx_p;
    grant        = '0;
    slot_en_next = '0;
    slot_sel     = '0;
    rr_ptr_next  = rr_ptr_reg;
    cnt          = 0;
    idx          = 0;
    idx_p        = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = int'(rr_ptr_reg) + j;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_p = PTR_W'(idx);
      if (!flush && req_valid[idx_p] && (cnt < WB_WIDTH)) begin
        grant[idx_p] = 1'b1;
        for (int k = 0; k < WB_WIDTH; k++) begin
          if (k == cnt) begin
            slot_en_next[k] = 1'b1;
            slot_sel[k]     = idx_p;
          end
        end
        cnt = cnt + 1;
        // The pointer moves to just past the last requester served.
        rr_ptr_next = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  assign req_ready = grant;

  // Priority pointer; it advances only when something was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // One registered writeback slot per ROB port.
  for (genvar gi = 0; gi < WB_WIDTH; gi++) begin : g_slot
    logic                            en_reg;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd_reg;
    logic [ROB_ADDR_WIDTH-1:0]       rob_addr_reg;
    logic [BANK_ADDR_WIDTH-1:0]      bank_addr_reg;

    // The enable pulses for one cycle; the payload holds while the slot is idle.
    always_ff @(posedge clk) begin
      if (rst) begin
        en_reg        <= 1'b0;
        phys_rd_reg   <= '0;
        rob_addr_reg  <= '0;
        bank_addr_reg <= '0;
      end else begin
        en_reg <= slot_en_next[gi];
        if (slot_en_next[gi]) begin
          phys_rd_reg   <= req_phys_rd[slot_sel[gi]];
          rob_addr_reg  <= req_rob_addr[slot_sel[gi]];
          bank_addr_reg <= req_bank_addr[slot_sel[gi]];
        end
      end
    end

    assign wb_en[gi]        = en_reg;
    assign wb_phys_rd[gi]   = phys_rd_reg;
    assign wb_rob_addr[gi]  = rob_addr_reg;
    assign wb_bank_addr[gi] = bank_addr_reg;
  end

endmodule
